// File: rtl/vpu_ctrl_pkg.sv
// Shared types and constants for the vector control sequencer: control word layout,
// opcode decode table, FSM states and the per-stage pipeline record.
package vpu_ctrl_pkg;

  localparam int OPC_W    = 4;
  localparam int VLEN_MAX = 8;
  localparam int LANES    = 2;
  localparam int VL_W     = $clog2(VLEN_MAX + 1);
  localparam int LANE_SH  = $clog2(LANES);

  typedef struct packed {
    logic sel_pc;
    logic sel_dest;
    logic reg_rdv;
    logic reg_rds;
    logic sel_op;
    logic sel_ad;
    logic sel_int;
    logic sum_mem;
    logic sel_mem;
    logic sel_data;
    logic mem_wr;
    logic sel_wb;
    logic reg_wrv;
    logic reg_wrs;
  } ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FLUSH
  } state_e;

  typedef struct packed {
    logic             valid;
    ctrl_t            ctrl;
    logic [OPC_W-1:0] opcode;
    logic [LANES-1:0] lane_mask;
    logic [VL_W-1:0]  elem_base;
    logic             last;
  } stage_t;

  // Index 15 is the leftmost entry.
  localparam logic [15:0][13:0] DECODE_TABLE = {
    14'b11100001011000,  // F
    14'b01100000010010,  // E
    14'b00010100000101,  // D
    14'b01000000000101,  // C
    14'b00110010000100,  // B
    14'b00110010000100,  // A
    14'b00111010000100,  // 9
    14'b00111010000100,  // 8
    14'b00111010000100,  // 7
    14'b00111010000100,  // 6
    14'b00110010000100,  // 5
    14'b01100000111000,  // 4
    14'b01100000110010,  // 3
    14'b00100000000110,  // 2
    14'b00100000000110,  // 1
    14'b00000000000000   // 0
  };

  function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl);
    return (vl > VL_W'(VLEN_MAX)) ? VL_W'(VLEN_MAX) : vl;
  endfunction

  // Vector ops take ceil(vl/LANES) beats, scalar ops one, opcode 0 none.
  function automatic logic [VL_W-1:0] beat_count(input logic [OPC_W-1:0] opc,
                                                 input ctrl_t            c,
                                                 input logic [VL_W-1:0]  vl);
    logic [VL_W:0] sum;
    sum = {1'b0, clamp_vl(vl)} + (VL_W+1)'(LANES - 1);
    if (opc == '0)
      return '0;
    if (c.reg_rdv || c.reg_wrv)
      return VL_W'(sum >> LANE_SH);
    return VL_W'(1);
  endfunction

endpackage

// File: rtl/vpu_ctrl_decode.sv
// Combinational opcode to control-word lookup.
module vpu_ctrl_decode
  import vpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  output ctrl_t            o_ctrl
);

  assign o_ctrl = ctrl_t'(DECODE_TABLE[i_opcode]);

endmodule

// File: rtl/vpu_ctrl_seq.sv
// Vector control sequencer: accepts an opcode + length, splits it into LANES-wide beats
// and carries each beat's control word through DEC->EXE->MEM->WB registers.
module vpu_ctrl_seq
  import vpu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_instr_valid,
  output logic             o_instr_ready,
  input  logic [OPC_W-1:0] i_opcode_in,
  input  logic [VL_W-1:0]  i_vl_in,
  input  logic             i_stall_in,
  output logic             o_dec_valid,
  output logic             o_exe_valid,
  output logic             o_mem_valid,
  output logic             o_wb_valid,
  output logic [13:0]      o_dec_ctrl,
  output logic [13:0]      o_exe_ctrl,
  output logic [13:0]      o_mem_ctrl,
  output logic [13:0]      o_wb_ctrl,
  output logic [OPC_W-1:0] o_exe_opcode,
  output logic [LANES-1:0] o_wb_lane_mask,
  output logic [VL_W-1:0]  o_wb_elem_base,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pc_redirect
);

  state_e           r_state, w_state_nxt;
  stage_t           r_dec, r_exe, r_mem, r_wb;
  stage_t           w_beat;
  ctrl_t            r_ctrl, w_dec_ctrl, w_src_ctrl;
  logic [OPC_W-1:0] r_opcode, w_src_opcode;
  logic [VL_W-1:0]  r_vl, r_beats, r_beat_idx;
  logic [VL_W-1:0]  w_vl_clamp, w_beats_in;
  logic [VL_W-1:0]  w_src_vl, w_src_beats, w_src_idx, w_elem_base;
  logic             r_zero_done;
  logic             w_accept, w_issue, w_stages_empty, w_pc_redirect;
  logic             w_unused_wb_opcode;

  vpu_ctrl_decode u_decode (
    .i_opcode (i_opcode_in),
    .o_ctrl   (w_dec_ctrl)
  );

  assign w_vl_clamp     = clamp_vl(i_vl_in);
  assign w_beats_in     = beat_count(i_opcode_in, w_dec_ctrl, i_vl_in);
  assign o_instr_ready  = rst_n && (r_state == IDLE) && !i_stall_in;
  assign w_accept       = i_instr_valid && o_instr_ready;
  assign w_issue        = (w_accept && (w_beats_in != '0)) ||
                          ((r_state == ISSUE) && !i_stall_in);
  assign w_stages_empty = !(r_dec.valid || r_exe.valid || r_mem.valid || r_wb.valid);
  assign w_pc_redirect  = (r_state == FLUSH) && w_stages_empty && !i_stall_in;

  // Beat 0 comes straight from the decoder; later beats replay the latched instruction.
  assign w_src_ctrl   = (r_state == IDLE) ? w_dec_ctrl  : r_ctrl;
  assign w_src_opcode = (r_state == IDLE) ? i_opcode_in : r_opcode;
  assign w_src_vl     = (r_state == IDLE) ? w_vl_clamp  : r_vl;
  assign w_src_beats  = (r_state == IDLE) ? w_beats_in  : r_beats;
  assign w_src_idx    = (r_state == IDLE) ? '0          : r_beat_idx;
  assign w_elem_base  = VL_W'(w_src_idx << LANE_SH);

  always_comb begin
    w_beat           = '0;
    w_beat.valid     = 1'b1;
    w_beat.ctrl      = w_src_ctrl;
    w_beat.opcode    = w_src_opcode;
    w_beat.elem_base = w_elem_base;
    w_beat.last      = (w_src_idx + VL_W'(1)) == w_src_beats;
    for (int i = 0; i < LANES; i++)
      w_beat.lane_mask[i] = ({1'b0, w_elem_base} + (VL_W+1)'(i)) < {1'b0, w_src_vl};
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, ISSUE: begin
        if (w_issue && w_beat.last)
          w_state_nxt = w_src_ctrl.sel_pc ? FLUSH : IDLE;
        else if (w_issue)
          w_state_nxt = ISSUE;
      end
      FLUSH: begin
        if (w_pc_redirect)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else if (!i_stall_in)
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec       <= '0;
      r_exe       <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_ctrl      <= '0;
      r_opcode    <= '0;
      r_vl        <= '0;
      r_beats     <= '0;
      r_beat_idx  <= '0;
      r_zero_done <= 1'b0;
    end else if (!i_stall_in) begin
      r_wb        <= r_mem;
      r_mem       <= r_exe;
      r_exe       <= r_dec;
      r_dec       <= w_issue ? w_beat : '0;
      r_zero_done <= w_accept && (w_beats_in == '0);
      if (w_accept) begin
        r_ctrl     <= w_dec_ctrl;
        r_opcode   <= i_opcode_in;
        r_vl       <= w_vl_clamp;
        r_beats    <= w_beats_in;
        r_beat_idx <= VL_W'(1);
      end else if (w_issue) begin
        r_beat_idx <= r_beat_idx + VL_W'(1);
      end
    end
  end

  assign o_dec_valid    = r_dec.valid;
  assign o_exe_valid    = r_exe.valid;
  assign o_mem_valid    = r_mem.valid;
  assign o_wb_valid     = r_wb.valid;
  assign o_dec_ctrl     = r_dec.valid ? 14'(r_dec.ctrl) : '0;
  assign o_exe_ctrl     = r_exe.valid ? 14'(r_exe.ctrl) : '0;
  assign o_mem_ctrl     = r_mem.valid ? 14'(r_mem.ctrl) : '0;
  assign o_wb_ctrl      = r_wb.valid  ? 14'(r_wb.ctrl)  : '0;
  assign o_exe_opcode   = r_exe.opcode;
  assign o_wb_lane_mask = r_wb.lane_mask;
  assign o_wb_elem_base = r_wb.elem_base;
  assign o_busy         = (r_state != IDLE) || !w_stages_empty;
  assign o_done         = !i_stall_in && (r_zero_done || (r_wb.valid && r_wb.last));
  assign o_pc_redirect  = w_pc_redirect;

  assign w_unused_wb_opcode = ^r_wb.opcode;

endmodule
